control_unit: RTL and testbench

Multi-cycle control sequencer for the 8-bit RISC datapath. It sits directly upstream of the five-stage datapath top: it consumes the 5-bit opcode field `Oi` and the registered N/Z flags `IFgn`/`IFgz`, and drives every datapath control strobe and mux select. Instructions run through a FETCH/DECODE/EXEC/(MEM|WB) state machine, taking 2–4 cycles each.

---
 rtl/cu_pkg.sv | 64 ++++++
 rtl/cu_decoder.sv | 50 +++++
 rtl/control_unit.sv | 193 +++++++++++++++++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the control_unit slice.
//   state_t  - sequencer states (S_PAUSE only exists when CU_SINGLE_STEP_EN
//              is defined)
//   iclass_t - instruction class produced by cu_decoder
//   OPC_*    - 4-bit opcode values (Oi[4:1]); OP_NOP / OP_HALT are full
//              5-bit encodings since they share opcode 0 and differ in Oi[0]
//   ALU_*    - OPALU codes
//   WB_*     - WBCR writeback select encodings
//   PC_*     - mux1CR PC source encodings
package cu_pkg;

`ifdef CU_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;
`endif

  typedef enum logic [2:0] {
    CL_NOP, CL_HALT, CL_ALU, CL_LOAD, CL_STORE, CL_OUT, CL_JUMP, CL_BRANCH
  } iclass_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;

  localparam logic [3:0] OPC_SYS = 4'h0;
  localparam logic [3:0] OPC_ADD = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_AND = 4'h3;
  localparam logic [3:0] OPC_OR  = 4'h4;
  localparam logic [3:0] OPC_XOR = 4'h5;
  localparam logic [3:0] OPC_NOT = 4'h6;
  localparam logic [3:0] OPC_SHL = 4'h7;
  localparam logic [3:0] OPC_SHR = 4'h8;
  localparam logic [3:0] OPC_LDI = 4'h9;
  localparam logic [3:0] OPC_LD  = 4'hA;
  localparam logic [3:0] OPC_ST  = 4'hB;
  localparam logic [3:0] OPC_IN  = 4'hC;
  localparam logic [3:0] OPC_OUT = 4'hD;
  localparam logic [3:0] OPC_JMP = 4'hE;
  localparam logic [3:0] OPC_BRC = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_SHL  = 4'b0110;
  localparam logic [3:0] ALU_SHR  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1000;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_RB  = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_TGT = 2'b01;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational opcode decode.
//   op      in  5  latched opcode field (op[4:1] opcode, op[0] sub-op)
//   iclass  out    instruction class
//   alu_op  out 4  OPALU value for ALU-class instructions (PASS otherwise)
//   wb_sel  out 2  WBCR value used in the WB state
//   in_sel  out 1  mux2CR value used in the WB state (1 for IN)
module cu_decoder
  import cu_pkg::*;
(
  input  logic [4:0] op,
  output iclass_t    iclass,
  output logic [3:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       in_sel
);

  always_comb begin
    iclass = CL_NOP;
    alu_op = ALU_PASS;
    wb_sel = WB_ALU;
    in_sel = 1'b0;
    case (op[4:1])
      OPC_SYS: iclass = op[0] ? CL_HALT : CL_NOP;
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_NOT, OPC_SHL, OPC_SHR: begin
        iclass = CL_ALU;
        // ALU codes are the opcode shifted down by one.
        alu_op = op[4:1] - 4'd1;
      end
      OPC_LDI: begin
        iclass = CL_LOAD;
        wb_sel = WB_IMM;
      end
      OPC_LD: begin
        iclass = CL_LOAD;
        wb_sel = WB_MEM;
      end
      OPC_IN: begin
        iclass = CL_LOAD;
        in_sel = 1'b1;
      end
      OPC_ST:  iclass = CL_STORE;
      OPC_OUT: iclass = CL_OUT;
      OPC_JMP: iclass = CL_JUMP;
      OPC_BRC: iclass = CL_BRANCH;
      default: iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/(MEM|WB) sequencer for the
// 8-bit RISC datapath.
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   step           single-step advance (only with CU_SINGLE_STEP_EN)
//   Oi[4:0]        opcode field, captured in DECODE
//   IFgn/IFgz      N/Z flags, sampled in EXEC for BRc
//   LRCR, PCCR     IR load, PC update enable
//   mux1CR[1:0]    PC source (00 PC+1, 01 target)
//   RegCR, mux2CR  register write enable, write data select (1 = in port)
//   OPALU[3:0]     ALU operation
//   NFCR, ZFCR     flag update enables
//   DMCR           data memory write enable
//   WBCR[1:0]      writeback select
//   Reg1CR, Reg2CR output port latch enables
//   halted         high in HALT
//   retire         pulse in the last cycle of each instruction
// Optional feature macro: CU_SINGLE_STEP_EN (adds step port and PAUSE state).
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [4:0] Oi,
  input  logic       IFgn,
  input  logic       IFgz,
  output logic       LRCR,
  output logic       PCCR,
  output logic [1:0] mux1CR,
  output logic       RegCR,
  output logic       mux2CR,
  output logic [3:0] OPALU,
  output logic       NFCR,
  output logic       ZFCR,
  output logic       DMCR,
  output logic [1:0] WBCR,
  output logic       Reg1CR,
  output logic       Reg2CR,
  output logic       halted,
  output logic       retire
);

`ifdef CU_SINGLE_STEP_EN
  localparam state_t RETIRE_STATE = S_PAUSE;
`else
  localparam state_t RETIRE_STATE = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [4:0] op_q;

  iclass_t    dec_class;
  logic [3:0] dec_alu;
  logic [1:0] dec_wb;
  logic       dec_in;
  logic       br_taken;

  cu_decoder u_dec (
    .op     (op_q),
    .iclass (dec_class),
    .alu_op (dec_alu),
    .wb_sel (dec_wb),
    .in_sel (dec_in)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= Oi;
    end
  end

  assign br_taken = op_q[0] ? IFgn : IFgz;

  always_comb begin
    state_d = state_q;
    LRCR    = 1'b0;
    PCCR    = 1'b0;
    mux1CR  = PC_INC;
    RegCR   = 1'b0;
    mux2CR  = 1'b0;
    OPALU   = ALU_PASS;
    NFCR    = 1'b0;
    ZFCR    = 1'b0;
    DMCR    = 1'b0;
    WBCR    = WB_ALU;
    Reg1CR  = 1'b0;
    Reg2CR  = 1'b0;
    halted  = 1'b0;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        LRCR    = 1'b1;
        PCCR    = 1'b1;
        state_d = S_DECODE;
      end
      // op_q is not loaded until the end of DECODE, so NOP must be seen
      // on Oi directly to retire in this cycle.
      S_DECODE: begin
        if (Oi == OP_NOP) begin
          retire  = 1'b1;
          state_d = RETIRE_STATE;
        end else if (Oi == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_class)
          CL_ALU: begin
            OPALU   = dec_alu;
            NFCR    = 1'b1;
            ZFCR    = 1'b1;
            state_d = S_WB;
          end
          CL_LOAD:  state_d = S_WB;
          CL_STORE: state_d = S_MEM;
          CL_OUT: begin
            Reg1CR  = 1'b1;
            Reg2CR  = 1'b1;
            retire  = 1'b1;
            state_d = RETIRE_STATE;
          end
          CL_JUMP: begin
            PCCR    = 1'b1;
            mux1CR  = PC_TGT;
            retire  = 1'b1;
            state_d = RETIRE_STATE;
          end
          CL_BRANCH: begin
            if (br_taken) begin
              PCCR   = 1'b1;
              mux1CR = PC_TGT;
            end
            retire  = 1'b1;
            state_d = RETIRE_STATE;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        DMCR    = 1'b1;
        retire  = 1'b1;
        state_d = RETIRE_STATE;
      end
      S_WB: begin
        RegCR   = 1'b1;
        WBCR    = dec_wb;
        mux2CR  = dec_in;
        retire  = 1'b1;
        state_d = RETIRE_STATE;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
`ifdef CU_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // state_q resets to FETCH, whose decode would assert LRCR/PCCR; hold
    // every output at its idle value while reset is asserted.
    if (!rst) begin
      LRCR   = 1'b0;
      PCCR   = 1'b0;
      mux1CR = PC_INC;
      RegCR  = 1'b0;
      mux2CR = 1'b0;
      OPALU  = ALU_PASS;
      NFCR   = 1'b0;
      ZFCR   = 1'b0;
      DMCR   = 1'b0;
      WBCR   = WB_ALU;
      Reg1CR = 1'b0;
      Reg2CR = 1'b0;
      halted = 1'b0;
      retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: per-cycle table of {Oi, flags, expected
// outputs} run from reset release, plus hand sequences for HALT, reset
// during EXEC and (with CU_SINGLE_STEP_EN) single-step pausing.
// Output bundle order: LRCR PCCR mux1CR RegCR mux2CR OPALU NFCR ZFCR DMCR
// WBCR Reg1CR Reg2CR halted retire (19 bits).
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [4:0] Oi = 5'b0;
  logic       IFgn = 1'b0, IFgz = 1'b0;
  logic       LRCR, PCCR, RegCR, mux2CR, NFCR, ZFCR, DMCR;
  logic       Reg1CR, Reg2CR, halted, retire;
  logic [1:0] mux1CR, WBCR;
  logic [3:0] OPALU;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CU_SINGLE_STEP_EN
    .step   (step),
`endif
    .Oi     (Oi),
    .IFgn   (IFgn),
    .IFgz   (IFgz),
    .LRCR   (LRCR),
    .PCCR   (PCCR),
    .mux1CR (mux1CR),
    .RegCR  (RegCR),
    .mux2CR (mux2CR),
    .OPALU  (OPALU),
    .NFCR   (NFCR),
    .ZFCR   (ZFCR),
    .DMCR   (DMCR),
    .WBCR   (WBCR),
    .Reg1CR (Reg1CR),
    .Reg2CR (Reg2CR),
    .halted (halted),
    .retire (retire)
  );

  function automatic logic [18:0] o(input logic lr, input logic pc,
      input logic [1:0] m1, input logic rg, input logic m2,
      input logic [3:0] alu, input logic nf, input logic zf, input logic dm,
      input logic [1:0] wb, input logic r1, input logic r2, input logic h,
      input logic rt);
    return {lr, pc, m1, rg, m2, alu, nf, zf, dm, wb, r1, r2, h, rt};
  endfunction

  function automatic logic [18:0] cur();
    return {LRCR, PCCR, mux1CR, RegCR, mux2CR, OPALU, NFCR, ZFCR, DMCR,
            WBCR, Reg1CR, Reg2CR, halted, retire};
  endfunction

  task automatic chk(input string name, input logic [18:0] act,
                     input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  oi;
    logic        gn;
    logic        gz;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [4:0] oi, input logic gn,
                     input logic gz, input logic [18:0] e);
    vec_t v;
    v.name = n; v.oi = oi; v.gn = gn; v.gz = gz; v.exp = e;
    vecs.push_back(v);
  endtask

  logic [18:0] IDLE, FET, WB_ALU_V;

  initial begin
    IDLE     = o(0,0,2'b00,0,0,4'h8,0,0,0,2'b00,0,0,0,0);
    FET      = o(1,1,2'b00,0,0,4'h8,0,0,0,2'b00,0,0,0,0);
    WB_ALU_V = o(0,0,2'b00,1,0,4'h8,0,0,0,2'b00,0,0,0,1);

    // ADD / SUB / SHR: 4 cycles, OPALU = opcode-1 in EXEC
    add("add.fetch", 5'b00010, 0, 0, FET);
    add("add.decode", 5'b00010, 0, 0, IDLE);
    add("add.exec", 5'b00010, 0, 0, o(0,0,2'b00,0,0,4'h0,1,1,0,2'b00,0,0,0,0));
    add("add.wb", 5'b00010, 0, 0, WB_ALU_V);
    add("sub.fetch", 5'b00100, 0, 0, FET);
    add("sub.decode", 5'b00100, 0, 0, IDLE);
    add("sub.exec", 5'b00100, 0, 0, o(0,0,2'b00,0,0,4'h1,1,1,0,2'b00,0,0,0,0));
    add("sub.wb", 5'b00100, 0, 0, WB_ALU_V);
    add("shr.fetch", 5'b10000, 0, 0, FET);
    add("shr.decode", 5'b10000, 0, 0, IDLE);
    add("shr.exec", 5'b10000, 0, 0, o(0,0,2'b00,0,0,4'h7,1,1,0,2'b00,0,0,0,0));
    add("shr.wb", 5'b10000, 0, 0, WB_ALU_V);
    // LDI / LD / IN: silent EXEC, writeback source differs
    add("ldi.fetch", 5'b10010, 0, 0, FET);
    add("ldi.decode", 5'b10010, 0, 0, IDLE);
    add("ldi.exec", 5'b10010, 0, 0, IDLE);
    add("ldi.wb", 5'b10010, 0, 0, o(0,0,2'b00,1,0,4'h8,0,0,0,2'b11,0,0,0,1));
    add("ld.fetch", 5'b10100, 0, 0, FET);
    add("ld.decode", 5'b10100, 0, 0, IDLE);
    add("ld.exec", 5'b10100, 0, 0, IDLE);
    add("ld.wb", 5'b10100, 0, 0, o(0,0,2'b00,1,0,4'h8,0,0,0,2'b01,0,0,0,1));
    add("in.fetch", 5'b11000, 0, 0, FET);
    add("in.decode", 5'b11000, 0, 0, IDLE);
    add("in.exec", 5'b11000, 0, 0, IDLE);
    add("in.wb", 5'b11000, 0, 0, o(0,0,2'b00,1,1,4'h8,0,0,0,2'b00,0,0,0,1));
    // ST: DMCR only in cycle 4, never RegCR
    add("st.fetch", 5'b10110, 0, 0, FET);
    add("st.decode", 5'b10110, 0, 0, IDLE);
    add("st.exec", 5'b10110, 0, 0, IDLE);
    add("st.mem", 5'b10110, 0, 0, o(0,0,2'b00,0,0,4'h8,0,0,1,2'b00,0,0,0,1));
    // OUT / JMP: 3 cycles
    add("out.fetch", 5'b11010, 0, 0, FET);
    add("out.decode", 5'b11010, 0, 0, IDLE);
    add("out.exec", 5'b11010, 0, 0, o(0,0,2'b00,0,0,4'h8,0,0,0,2'b00,1,1,0,1));
    add("jmp.fetch", 5'b11100, 0, 0, FET);
    add("jmp.decode", 5'b11100, 0, 0, IDLE);
    add("jmp.exec", 5'b11100, 0, 0, o(0,1,2'b01,0,0,4'h8,0,0,0,2'b00,0,0,0,1));
    // BRc: sub-op 1 tests N, 0 tests Z; the other flag is set opposite
    add("brn_t.fetch", 5'b11111, 1, 0, FET);
    add("brn_t.decode", 5'b11111, 1, 0, IDLE);
    add("brn_t.exec", 5'b11111, 1, 0, o(0,1,2'b01,0,0,4'h8,0,0,0,2'b00,0,0,0,1));
    add("brn_n.fetch", 5'b11111, 0, 1, FET);
    add("brn_n.decode", 5'b11111, 0, 1, IDLE);
    add("brn_n.exec", 5'b11111, 0, 1, o(0,0,2'b00,0,0,4'h8,0,0,0,2'b00,0,0,0,1));
    add("brz_t.fetch", 5'b11110, 0, 1, FET);
    add("brz_t.decode", 5'b11110, 0, 1, IDLE);
    add("brz_t.exec", 5'b11110, 0, 1, o(0,1,2'b01,0,0,4'h8,0,0,0,2'b00,0,0,0,1));
    add("brz_n.fetch", 5'b11110, 1, 0, FET);
    add("brz_n.decode", 5'b11110, 1, 0, IDLE);
    add("brz_n.exec", 5'b11110, 1, 0, o(0,0,2'b00,0,0,4'h8,0,0,0,2'b00,0,0,0,1));
    // NOP: 2 cycles, retires in DECODE
    add("nop.fetch", 5'b00000, 0, 0, FET);
    add("nop.decode", 5'b00000, 0, 0, o(0,0,2'b00,0,0,4'h8,0,0,0,2'b00,0,0,0,1));
    // HALT: halted from cycle 3
    add("halt.fetch", 5'b00001, 0, 0, FET);
    add("halt.decode", 5'b00001, 0, 0, IDLE);
    add("halt.c3", 5'b00001, 0, 0, o(0,0,2'b00,0,0,4'h8,0,0,0,2'b00,0,0,1,0));

    // Reset
    step = 1'b1;
    #2 rst = 1'b0;
    #1 chk("reset_values", cur(), IDLE);
    repeat (2) @(negedge clk);
    chk("reset_hold", cur(), IDLE);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      Oi = vecs[i].oi; IFgn = vecs[i].gn; IFgz = vecs[i].gz;
      #1 chk(vecs[i].name, cur(), vecs[i].exp);
      @(negedge clk);
`ifdef CU_SINGLE_STEP_EN
      if (vecs[i].exp[0]) begin
        #1 chk({vecs[i].name, ".pause"}, cur(), IDLE);
        @(negedge clk);
      end
`endif
    end

    // Stays halted with no fetch for 20 cycles
    for (int i = 0; i < 20; i++) begin
      #1 chk("halt.hold", {LRCR, halted}, 2'b01);
      @(negedge clk);
    end
    rst = 1'b0;
    #1 chk("halt.reset_exit", cur(), IDLE);
    @(negedge clk);

    // Reset asserted during EXEC of ADD
    Oi = 5'b00010; IFgn = 1'b0; IFgz = 1'b0;
    rst = 1'b1;
    #1 chk("mid.fetch", cur(), FET);
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid.exec", cur(), o(0,0,2'b00,0,0,4'h0,1,1,0,2'b00,0,0,0,0));
    #2 rst = 1'b0;
    #1 chk("mid.reset_now", cur(), IDLE);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("mid.no_regcr", cur(), IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid.first_fetch", cur(), FET);
    @(negedge clk);
    #1 chk("mid.decode", cur(), IDLE);

`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("step.wb", cur(), WB_ALU_V);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 chk("step.paused", cur(), IDLE);
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    #1 chk("step.fetch", cur(), FET);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
